// File: rtl/poly_solver_rr_arbiter.sv
// Round-robin arbiter sharing one polynomial solver among N requesters.
// Grants one requester, starts the solver, waits for done or timeout, acks.
module poly_solver_rr_arbiter #(
    parameter int N              = 4,
    parameter int IN_W           = 2,
    parameter int OUT_W          = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req,
    input  logic [N*IN_W-1:0] req_x,
    output logic              solver_start,
    output logic [IN_W-1:0]   solver_in,
    input  logic              solver_done,
    input  logic [OUT_W-1:0]  solver_out,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      ack,
    output logic [OUT_W-1:0]  result,
    output logic              resp_err,
    output logic              busy
);
    localparam int PW = $clog2(N);
    localparam int IW = PW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IN_W-1:0]   in_q, in_d;
    logic [OUT_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              found;
    logic [PW-1:0]     win_c;
    logic [IW-1:0]     idx;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr_q} + IW'(i);
            if (idx >= IW'(N))
                idx = idx - IW'(N);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win_c = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        in_d     = in_q;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = win_c;
                    gnt_d   = ONE << win_c;
                    in_d    = req_x[win_c*IN_W +: IN_W];
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (solver_done) begin
                    res_d   = solver_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                gnt_d    = '0;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            in_q     <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            in_q     <= in_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign solver_start = (state_q == START);
    assign solver_in    = in_q;
    assign gnt          = gnt_q;
    assign ack          = (state_q == RESP) ? gnt_q : '0;
    assign result       = res_q;
    assign resp_err     = err_q;
    assign busy         = (state_q != IDLE);

endmodule
